// File: rtl/rr_sel4.sv
// Round-robin select generator for a 4:1 mux.
// Bounded-beat grants rotate fairly across the four request lines.
module rr_sel4 #(
    parameter int HOLD_MAX = 4,
    parameter int CNT_W    = 3
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [3:0] req,
    input  logic       out_ready,
    output logic [1:0] S,
    output logic [3:0] gnt,
    output logic       sel_valid
);

    typedef enum logic {
        IDLE,
        GRANT
    } state_t;

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(HOLD_MAX - 1);

    state_t           state_q;
    logic [1:0]       ptr_q;
    logic [1:0]       s_q;
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;
    logic [3:0]       gnt_q;
    logic             valid_q;

    logic [1:0] win_d;
    logic [1:0] idx;
    logic       any_req;
    logic       release_c;

    // Scan from ptr downward so the nearest requester is assigned last.
    always_comb begin
        win_d   = ptr_q;
        idx     = ptr_q;
        any_req = 1'b0;
        for (int k = 3; k >= 0; k--) begin
            idx = ptr_q + 2'(k);
            if (req[idx]) begin
                win_d   = idx;
                any_req = 1'b1;
            end
        end
    end

    always_comb begin
        cnt_d     = cnt_q + 1'b1;
        release_c = !req[s_q] || (out_ready && (cnt_q == CNT_LAST));
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            ptr_q   <= 2'd0;
            s_q     <= 2'd0;
            cnt_q   <= '0;
            gnt_q   <= 4'd0;
            valid_q <= 1'b0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (any_req) begin
                        state_q <= GRANT;
                        s_q     <= win_d;
                        gnt_q   <= 4'b0001 << win_d;
                        valid_q <= 1'b1;
                        cnt_q   <= '0;
                    end
                end
                GRANT: begin
                    if (release_c) begin
                        state_q <= IDLE;
                        valid_q <= 1'b0;
                        gnt_q   <= 4'd0;
                        ptr_q   <= s_q + 2'd1;
                        cnt_q   <= '0;
                    end else if (out_ready) begin
                        cnt_q <= cnt_d;
                    end
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign S         = s_q;
    assign gnt       = gnt_q;
    assign sel_valid = valid_q;

endmodule

// File: tb/tb_rr_sel4.sv
// Bench for rr_sel4: directed scenarios plus random traffic,
// all checked every cycle against a beat-counting grant model.
module tb_rr_sel4;

    localparam int HM = 4;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [3:0] req = 4'd0;
    logic       out_ready = 1'b0;
    logic [1:0] S;
    logic [3:0] gnt;
    logic       sel_valid;

    int checks = 0;
    int failures = 0;

    bit m_busy;
    int m_S;
    int m_beats;
    int m_ptr;

    rr_sel4 #(.HOLD_MAX(HM), .CNT_W(3)) dut (
        .clk(clk),
        .rst_n(rst_n),
        .req(req),
        .out_ready(out_ready),
        .S(S),
        .gnt(gnt),
        .sel_valid(sel_valid)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [6:0] got,
                       input logic [6:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got S/gnt/v=%b required=%b at %0t",
                     name, got, exp, $time);
        end
    endtask

    function automatic logic [6:0] model_out();
        logic [3:0] g;
        g = m_busy ? (4'b0001 << m_S) : 4'b0000;
        return {2'(m_S), g, m_busy};
    endfunction

    task automatic model_reset();
        m_busy = 0;
        m_S = 0;
        m_beats = 0;
        m_ptr = 0;
    endtask

    // Grant owner keeps the mux until its request drops or HM beats pass.
    task automatic model_edge();
        if (!m_busy) begin
            for (int k = 0; k < 4; k++) begin
                int c;
                c = (m_ptr + k) % 4;
                if (req[c]) begin
                    m_busy = 1;
                    m_S = c;
                    m_beats = 0;
                    break;
                end
            end
        end else begin
            if (out_ready) m_beats++;
            if (!req[m_S] || m_beats == HM) begin
                m_busy = 0;
                m_ptr = (m_S + 1) % 4;
                m_beats = 0;
            end
        end
    endtask

    task automatic step(input logic [3:0] r, input logic rd);
        req = r;
        out_ready = rd;
        @(posedge clk);
        model_edge();
        @(negedge clk);
        chk("cycle", {S, gnt, sel_valid}, model_out());
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        #1;
        model_reset();
        chk("async_reset", {S, gnt, sel_valid}, 7'd0);
        req = 4'd0;
        out_ready = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        logic [9:0] pat;
        model_reset();
        @(negedge clk);
        @(negedge clk);
        chk("reset_state", {S, gnt, sel_valid}, 7'd0);
        rst_n = 1'b1;
        step(4'b0000, 1'b1);
        step(4'b0000, 1'b1);
        chk("idle_after_reset", {S, gnt, sel_valid}, 7'd0);

        // Single requester on channel 2: four beats, one idle cycle.
        pat = 10'b1111011110;
        for (int i = 0; i < 10; i++) begin
            step(4'b0100, 1'b1);
            chk("single", {S, gnt, sel_valid},
                pat[9-i] ? {2'd2, 4'b0100, 1'b1} : {2'd2, 4'b0000, 1'b0});
        end
        step(4'b0100, 1'b1);
        chk("single_regrant", {S, gnt, sel_valid}, {2'd2, 4'b0100, 1'b1});

        // Reset in the middle of the S=2 grant.
        #2;
        do_reset();
        step(4'b0000, 1'b1);
        chk("idle_post_reset", {S, gnt, sel_valid}, 7'd0);

        // Full contention: 0,1,2,3,0 with a one-cycle gap after each.
        for (int i = 0; i < 21; i++) begin
            int s;
            bit v;
            step(4'b1111, 1'b1);
            s = (i / 5) % 4;
            v = (i % 5) != 4;
            chk("contention", {S, gnt, sel_valid},
                {2'(s), v ? (4'b0001 << s) : 4'b0000, v});
        end

        // Early drop on channel 1 after two beats.
        do_reset();
        step(4'b0010, 1'b1);
        step(4'b0010, 1'b1);
        step(4'b0010, 1'b1);
        chk("drop_hold", {S, gnt, sel_valid}, {2'd1, 4'b0010, 1'b1});
        step(4'b1001, 1'b1);
        chk("drop_release", {S, gnt, sel_valid}, {2'd1, 4'b0000, 1'b0});
        step(4'b1001, 1'b1);
        chk("drop_next", {S, gnt, sel_valid}, {2'd3, 4'b1000, 1'b1});

        // Stall for ten cycles, then exactly four beats.
        do_reset();
        step(4'b0001, 1'b1);
        for (int i = 0; i < 10; i++) step(4'b0001, 1'b0);
        chk("stall_hold", {S, gnt, sel_valid}, {2'd0, 4'b0001, 1'b1});
        for (int i = 0; i < 3; i++) begin
            step(4'b0001, 1'b1);
            chk("stall_beats", {S, gnt, sel_valid}, {2'd0, 4'b0001, 1'b1});
        end
        step(4'b0001, 1'b1);
        chk("stall_release", {S, gnt, sel_valid}, {2'd0, 4'b0000, 1'b0});

        // Last beat and request drop coincide on channel 3.
        do_reset();
        step(4'b1000, 1'b1);
        step(4'b1000, 1'b1);
        step(4'b1000, 1'b1);
        step(4'b1000, 1'b1);
        chk("wrap_hold", {S, gnt, sel_valid}, {2'd3, 4'b1000, 1'b1});
        step(4'b0011, 1'b1);
        chk("wrap_release", {S, gnt, sel_valid}, {2'd3, 4'b0000, 1'b0});
        step(4'b0011, 1'b1);
        chk("wrap_next", {S, gnt, sel_valid}, {2'd0, 4'b0001, 1'b1});

        // Random traffic with sticky requests and bursty readiness.
        do_reset();
        begin
            logic [3:0] r;
            logic rd;
            r = 4'd0;
            for (int i = 0; i < 3000; i++) begin
                if ($urandom_range(0, 4) == 0) r = 4'($urandom);
                rd = ($urandom_range(0, 3) != 0);
                step(r, rd);
                if ($urandom_range(0, 499) == 0) begin
                    #2;
                    do_reset();
                end
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
